// File: rtl/control_pipe.sv
// Control-side pipeline for ID/EX, EX/MEM and MEM/WB, with load-use stall, flush and operand forwarding selects.
// Define CONTROL_PIPE_FWD_EN to enable forwarding; without it the selects are tied off and the stall widens.
module control_pipe #(
   parameter int REGW = 5
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic [8:0]      EX_in,
   input  logic [4:0]      M_in,
   input  logic [3:0]      WB_in,
   input  logic [REGW-1:0] RsID,
   input  logic [REGW-1:0] RtID,
   input  logic [REGW-1:0] DstID,
   input  logic            Flush,
   output logic [8:0]      EX_out,
   output logic [4:0]      M_out,
   output logic [3:0]      WB_out,
   output logic [REGW-1:0] DstMEM,
   output logic [REGW-1:0] DstWB,
   output logic            StallOut,
   output logic [1:0]      ForwardA,
   output logic [1:0]      ForwardB
);

   logic [8:0]      ex_p0;
   logic [4:0]      m_p0;
   logic [3:0]      wb_p0;
   logic [REGW-1:0] rs_p0;
   logic [REGW-1:0] rt_p0;
   logic [REGW-1:0] dst_p0;
   logic            vld_p0;

   logic [4:0]      m_p1;
   logic [3:0]      wb_p1;
   logic [REGW-1:0] dst_p1;
   logic            vld_p1;

   logic [3:0]      wb_p2;
   logic [REGW-1:0] dst_p2;
   logic            vld_p2;

   logic            hazard;

   // A live register-writing entry whose destination is a nonzero match for the probed index.
   function automatic logic dst_hit(input logic vld, input logic reg_write,
                                    input logic [REGW-1:0] dst, input logic [REGW-1:0] idx);
      return vld && reg_write && (dst != '0) && (dst == idx);
   endfunction

`ifdef CONTROL_PIPE_FWD_EN
   function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] idx);
      if (dst_hit(vld_p1, wb_p1[0], dst_p1, idx))
         return 2'b10;
      else if (dst_hit(vld_p2, wb_p2[0], dst_p2, idx))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign hazard   = m_p0[0] && (dst_hit(vld_p0, wb_p0[0], dst_p0, RsID) ||
                                 dst_hit(vld_p0, wb_p0[0], dst_p0, RtID));
   assign ForwardA = fwd_sel(rs_p0);
   assign ForwardB = fwd_sel(rt_p0);
`else
   // With no bypass network, any producer still in EX or MEM must be waited out.
   logic unused_rs_rt;
   assign unused_rs_rt = ^{rs_p0, rt_p0};
   assign hazard   = dst_hit(vld_p0, wb_p0[0], dst_p0, RsID) ||
                     dst_hit(vld_p0, wb_p0[0], dst_p0, RtID) ||
                     dst_hit(vld_p1, wb_p1[0], dst_p1, RsID) ||
                     dst_hit(vld_p1, wb_p1[0], dst_p1, RtID);
   assign ForwardA = 2'b00;
   assign ForwardB = 2'b00;
`endif

   assign StallOut = hazard && !Flush;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         ex_p0  <= '0;
         m_p0   <= '0;
         wb_p0  <= '0;
         rs_p0  <= '0;
         rt_p0  <= '0;
         dst_p0 <= '0;
         vld_p0 <= 1'b0;
         m_p1   <= '0;
         wb_p1  <= '0;
         dst_p1 <= '0;
         vld_p1 <= 1'b0;
         wb_p2  <= '0;
         dst_p2 <= '0;
         vld_p2 <= 1'b0;
      end else begin
         // MEM/WB boundary: always advances, even under flush or stall
         wb_p2  <= wb_p1;
         dst_p2 <= dst_p1;
         vld_p2 <= vld_p1;
         // EX/MEM boundary
         if (Flush) begin
            m_p1   <= '0;
            wb_p1  <= '0;
            dst_p1 <= '0;
            vld_p1 <= 1'b0;
         end else begin
            m_p1   <= m_p0;
            wb_p1  <= wb_p0;
            dst_p1 <= dst_p0;
            vld_p1 <= vld_p0;
         end
         // ID/EX boundary
         if (Flush || hazard) begin
            ex_p0  <= '0;
            m_p0   <= '0;
            wb_p0  <= '0;
            rs_p0  <= '0;
            rt_p0  <= '0;
            dst_p0 <= '0;
            vld_p0 <= 1'b0;
         end else begin
            ex_p0  <= EX_in;
            m_p0   <= M_in;
            wb_p0  <= WB_in;
            rs_p0  <= RsID;
            rt_p0  <= RtID;
            dst_p0 <= DstID;
            vld_p0 <= 1'b1;
         end
      end
   end

   assign EX_out = ex_p0;
   assign M_out  = m_p1;
   assign WB_out = wb_p2;
   assign DstMEM = dst_p1;
   assign DstWB  = dst_p2;

endmodule
